uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the UART transmit path (the TX FIFO write interface: w_data / wr_uart / tx_full) between NREQ byte-stream requesters. A grant is held for a whole packet, delimited by a last flag, so bytes from different requesters never interleave on the line. A stall timeout releases a grant whose owner stops supplying bytes. It sits between on-chip message sources (status, debug, loopback) and the UART top-level transmit port.

Parameters:
NREQ, 4, number of requesters (2..8)
DBIT, 8, data bits per byte; matches the UART DBIT
TIMEOUT, 1024, cycles a granted requester may hold req_valid low mid-packet before the grant is revoked (>=2)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester byte valid
req_data  input  NREQ*DBIT  per-requester byte; requester i occupies bits [i*DBIT +: DBIT]
req_last  input  NREQ  marks the final byte of a packet, qualified by req_valid
req_ready  output  NREQ  byte accepted this cycle when valid & ready
w_data  output  DBIT  byte to the TX FIFO
wr_uart  output  1  TX FIFO write strobe
tx_full  input  1  TX FIFO full
grant_id  output  clog2(NREQ)  index of the current owner; valid while busy
busy  output  1  a grant is held
timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE, busy=0, grant_id=0, rr_ptr=0, stall counter=0, timeout_err=0, req_ready=0, wr_uart=0. This takes effect immediately, including mid-packet. The partial packet is abandoned, and the FIFO contents are not this block's concern.
- States: IDLE and LOCK.
- IDLE:
  - If any req_valid is high, pick the first requester with req_valid set, searching circularly from rr_ptr upward with wrap from NREQ-1 to 0.
  - On the next edge: grant_id=pick, busy=1, state=LOCK.
  - No byte is transferred in IDLE, so arbitration costs exactly 1 cycle.
  - No requests: stay in IDLE.
- LOCK (owner g=grant_id):
  - req_ready[g] = ~tx_full. All other req_ready bits are 0.
  - wr_uart = req_valid[g] & ~tx_full, combinational.
  - w_data = req_data[g] slice, combinational.
  - A transfer occurs when wr_uart=1.
  - Transfer with req_last[g]=1: next edge state=IDLE, busy=0, rr_ptr=(g+1) mod NREQ. The block re-arbitrates the following cycle, so there is a 1-cycle gap between packets.
  - Stall counter: cleared on every transfer. Increments each cycle in LOCK with req_valid[g]=0. Holds while req_valid[g]=1 and tx_full=1, because FIFO backpressure is not a stall.
  - Counter reaching TIMEOUT-1 while still stalled: next edge state=IDLE, busy=0, rr_ptr=(g+1) mod NREQ, timeout_err pulses high for 1 cycle, counter cleared.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.
- Outside LOCK: wr_uart=0, w_data=0.
- Single-byte packet (valid and last together on the first LOCK cycle): 1 transfer, then IDLE.
- A requester deasserting req_valid while not granted is legal. req_valid and req_data must stay stable while valid is high and ready is low.
- Fairness: after any release, the releasing requester has the lowest priority. With all NREQ requesters continuously active, grants rotate 0,1,2,...,NREQ-1,0.
- If rr_ptr's requester is idle and several others are requesting, the search wrap decides the winner, e.g. rr_ptr=3, requests {0,2} -> grant 0.

Decomposition:
- Shared package uart_pkg holds: the state encoding enum (IDLE, LOCK), the default DBIT, and a clog2-based width helper constant for grant_id and the counter.
- One natural sub-module, rr_pick: a combinational circular priority encoder (inputs req vector and rr_ptr; outputs pick index and any). It is reusable for an RX-side demux later.
- The FSM, counter and muxing stay in uart_tx_arbiter.

Test Plan:
1. Reset, then requester 2 sends a 3-byte packet 0xA1,0xA2,0xA3 (last on 0xA3), tx_full=0 -> grant_id=2 after 1 cycle; wr_uart high 3 consecutive cycles with those bytes; busy drops the cycle after 0xA3; rr_ptr=3.
2. All 4 requesters hold 2-byte packets continuously from reset -> packets appear on w_data in order 0,1,2,3,0 with no byte interleaving and a 1-cycle gap between packets.
3. Requester 1 is granted, tx_full held high for 50 cycles mid-packet -> no wr_uart, no timeout_err, req_ready[1]=0; the packet completes intact once tx_full drops.
4. TIMEOUT=16: requester 0 sends 1 byte without last, then drops req_valid -> timeout_err pulses exactly 16 cycles after the last transfer; busy=0; a pending requester 3 is granted next.
5. reset_n asserted low mid-packet (during the 2nd of 4 bytes) -> wr_uart, busy and req_ready go low immediately; after release, arbitration restarts at rr_ptr=0.
6. rr_ptr=3 with only requesters 0 and 2 valid -> grant_id=0; single-byte packet with last on the first beat -> exactly one wr_uart pulse, then IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit-side arbiter and its
// combinational picker.
package uart_pkg;

  localparam int DBIT_DEF  = 8;
  // rr_ptr in the debug struct is sized for the largest supported NREQ (8)
  localparam int PTR_MAX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    arb_state_t            state;
    logic [PTR_MAX_W-1:0]  rr_ptr;
  } arb_dbg_t;

  // Index/counter width that never collapses to zero bits.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams on one side, the TX FIFO write port and grant status
// on the other.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
);
  import uart_pkg::*;

  localparam int GW = width_of(NREQ);

  // Handshake: a byte of requester i moves on a rising edge where
  // req_valid[i] & req_ready[i]; req_valid, req_data and req_last hold steady
  // until then. wr_uart is a plain write strobe, only raised while tx_full=0.
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic [DBIT-1:0]      w_data;
  logic                 wr_uart;
  logic                 tx_full;
  logic [GW-1:0]        grant_id;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, w_data, wr_uart, grant_id, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, w_data, wr_uart, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Circular priority encoder: first set bit of req, searching upward from ptr
// and wrapping from N-1 to 0.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] pick,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int i = 0; i < N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!any && req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the UART TX FIFO write port among
// NREQ byte streams; a grant lasts a whole packet or until a stall timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DBIT    = DBIT_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_arbiter_if.slave  bus,
  output arb_dbg_t          dbg
);

  localparam int GW = width_of(NREQ);
  localparam int CW = width_of(TIMEOUT + 1);

  arb_state_t      state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_ptr_q;
  logic            busy_q;
  logic            terr_q;
  logic [CW-1:0]   stall_q;

  logic [GW-1:0]   pick;
  logic            any_req;
  logic [GW-1:0]   next_ptr;
  logic            owner_valid;
  logic            owner_last;
  logic [DBIT-1:0] owner_data;
  logic [NREQ-1:0] ready_c;
  logic            xfer;
  logic [DBIT-1:0] w_data_c;

  rr_pick #(
    .N (NREQ),
    .W (GW)
  ) u_pick (
    .req  (bus.req_valid),
    .ptr  (rr_ptr_q),
    .pick (pick),
    .any  (any_req)
  );

  // Owner mux built from constant indices so non-power-of-two NREQ stays clean.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    ready_c     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_last  = bus.req_last[i];
        owner_data  = bus.req_data[i*DBIT +: DBIT];
        ready_c[i]  = (state_q == LOCK) && !bus.tx_full;
      end
    end
  end

  always_comb begin
    xfer     = (state_q == LOCK) && owner_valid && !bus.tx_full;
    w_data_c = (state_q == LOCK) ? owner_data : '0;
    next_ptr = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      stall_q  <= '0;
    end else begin
      terr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          stall_q <= '0;
          if (any_req) begin
            grant_q <= pick;
            busy_q  <= 1'b1;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (xfer) begin
            stall_q <= '0;
            if (owner_last) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              rr_ptr_q <= next_ptr;
            end
          end else if (!owner_valid) begin
            // Backpressure with valid high is not a stall; only a silent owner counts.
            if (stall_q == CW'(TIMEOUT - 1)) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              rr_ptr_q <= next_ptr;
              terr_q   <= 1'b1;
              stall_q  <= '0;
            end else if (stall_q != {CW{1'b1}}) begin
              stall_q <= stall_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.wr_uart     = xfer;
  assign bus.w_data      = w_data_c;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

  assign dbg.state  = state_q;
  assign dbg.rr_ptr = PTR_MAX_W'(rr_ptr_q);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four requesters fed from per-requester
// byte queues, FIFO side modelled by tx_full only.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  logic clk;
  logic reset_n;
  arb_dbg_t dbg;

  uart_tx_arbiter_if #(.NREQ(4), .DBIT(8)) bus ();

  uart_tx_arbiter #(
    .NREQ    (4),
    .DBIT    (8),
    .TIMEOUT (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .dbg     (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- requester state and scoreboard ----------------
  logic [7:0] q_data [4][$];
  logic       q_last [4][$];
  logic [3:0] hold;
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int         got_id_q [$];
  int         got_cyc_q [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic       s_wr, s_busy, s_terr;
  logic [7:0] s_wdata;
  logic [1:0] s_grant;
  logic [3:0] s_ready, s_fire;
  arb_state_t s_state;
  logic [2:0] s_ptr;

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]       = (q_data[i].size() > 0) && !hold[i];
      bus.req_data[i*8 +: 8] = (q_data[i].size() > 0) ? q_data[i][0] : 8'h00;
      bus.req_last[i]        = (q_last[i].size() > 0) ? q_last[i][0] : 1'b0;
    end
  endtask

  task automatic add_pkt(input int id, input int n, input logic [7:0] base, input logic last_en);
    for (int k = 0; k < n; k++) begin
      q_data[id].push_back(base + 8'(k));
      q_last[id].push_back(last_en && (k == n - 1));
    end
  endtask

  // Sample outputs on the falling edge, then retire accepted bytes after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    s_wr    = bus.wr_uart;
    s_wdata = bus.w_data;
    s_busy  = bus.busy;
    s_grant = bus.grant_id;
    s_terr  = bus.timeout_err;
    s_ready = bus.req_ready;
    s_state = dbg.state;
    s_ptr   = dbg.rr_ptr;
    s_fire  = bus.req_valid & bus.req_ready;
    if (s_wr) begin
      got_q.push_back(s_wdata);
      got_id_q.push_back(int'(s_grant));
      got_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (s_fire[i]) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
      end
    end
    drive();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    bus.tx_full = 1'b0;
    hold        = '0;
    for (int i = 0; i < 4; i++) begin
      q_data[i].delete();
      q_last[i].delete();
    end
    exp_q.delete();
    got_q.delete();
    got_id_q.delete();
    got_cyc_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_id); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got=%0b exp=0", bus.timeout_err); end
    checks++; if (bus.wr_uart !== 1'b0) begin errors++; $display("FAIL reset_wr got=%0b exp=0", bus.wr_uart); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.w_data !== 8'h00) begin errors++; $display("FAIL reset_wdata got=%0h exp=0", bus.w_data); end
    checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=IDLE", dbg.state); end
    checks++; if (dbg.rr_ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got=%0d exp=0", dbg.rr_ptr); end
  endtask

  task automatic test_single_packet();
    add_pkt(2, 3, 8'hA1, 1'b1);
    exp_q = '{8'hA1, 8'hA2, 8'hA3};
    drive();
    step();
    checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL t1_arb_wr got=%0b exp=0", s_wr); end
    step();
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL t1_busy got=%0b exp=1", s_busy); end
    checks++; if (s_grant !== 2'd2) begin errors++; $display("FAIL t1_grant got=%0d exp=2", s_grant); end
    checks++; if (s_ready !== 4'b0100) begin errors++; $display("FAIL t1_ready got=%b exp=0100", s_ready); end
    step();
    step();
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL t1_busy_last got=%0b exp=1", s_busy); end
    step();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL t1_release got=%0b exp=0", s_busy); end
    checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL t1_idle_wr got=%0b exp=0", s_wr); end
    checks++; if (s_ptr !== 3'd3) begin errors++; $display("FAIL t1_ptr got=%0d exp=3", s_ptr); end
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL t1_count got=%0d exp=3", got_q.size()); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL t1_byte%0d got=%0h exp=%0h", k, got_q[k], exp_q[k]); end
    end
    if (got_q.size() == 3) begin
      checks++;
      if (got_cyc_q[2] - got_cyc_q[0] !== 2) begin
        errors++; $display("FAIL t1_consecutive got=%0d exp=2", got_cyc_q[2] - got_cyc_q[0]);
      end
    end
  endtask

  task automatic test_round_robin();
    int bad;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        add_pkt(i, 2, 8'(16 * (i + 1) + 8 * r), 1'b1);
        exp_q.push_back(8'(16 * (i + 1) + 8 * r));
        exp_q.push_back(8'(16 * (i + 1) + 8 * r + 1));
      end
    drive();
    for (int k = 0; k < 60 && got_q.size() < 16; k++) step();
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL t2_count got=%0d exp=16", got_q.size()); end
    bad = 0;
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL t2_byte%0d got=%0h exp=%0h", k, got_q[k], exp_q[k]); end
      if (got_id_q[k] != (k / 2) % 4) bad++;
      // Bytes of one packet are back to back; packets are separated by one arbitration cycle.
      if (k > 0 && (got_cyc_q[k] - got_cyc_q[k-1]) != ((k % 2 == 1) ? 1 : 2)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL t2_order_gap got=%0d bad exp=0", bad); end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    add_pkt(1, 4, 8'h30, 1'b1);
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33};
    drive();
    for (int k = 0; k < 10 && got_q.size() < 1; k++) step();
    bus.tx_full = 1'b1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (s_wr || s_terr || s_ready[1] || !s_busy) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL t3_full_hold got=%0d bad cycles exp=0", bad); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL t3_during_full got=%0d exp=1", got_q.size()); end
    bus.tx_full = 1'b0;
    for (int k = 0; k < 20 && got_q.size() < 4; k++) step();
    step();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL t3_release got=%0b exp=0", s_busy); end
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL t3_count got=%0d exp=4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL t3_byte%0d got=%0h exp=%0h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_timeout();
    int t0;
    do_reset();
    add_pkt(0, 1, 8'h50, 1'b0);
    add_pkt(3, 1, 8'h5A, 1'b1);
    drive();
    for (int k = 0; k < 10 && got_q.size() < 1; k++) step();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL t4_first got=%0d exp=1", got_q.size()); end
    t0 = (got_cyc_q.size() > 0) ? got_cyc_q[0] : cyc;
    s_terr = 1'b0;
    for (int k = 0; k < 40 && !s_terr; k++) step();
    // 16 stall cycles follow the transfer; the pulse shows in the cycle after them.
    checks++; if (s_terr !== 1'b1) begin errors++; $display("FAIL t4_terr_seen got=%0b exp=1", s_terr); end
    checks++; if (cyc - t0 !== 17) begin errors++; $display("FAIL t4_terr_delay got=%0d exp=17", cyc - t0); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL t4_busy got=%0b exp=0", s_busy); end
    step();
    checks++; if (s_terr !== 1'b0) begin errors++; $display("FAIL t4_pulse_width got=%0b exp=0", s_terr); end
    checks++; if (s_grant !== 2'd3) begin errors++; $display("FAIL t4_next_grant got=%0d exp=3", s_grant); end
    checks++; if (s_wdata !== 8'h5A || s_wr !== 1'b1) begin errors++; $display("FAIL t4_next_byte got=%0h/%0b exp=5a/1", s_wdata, s_wr); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    add_pkt(2, 1, 8'h60, 1'b1);
    drive();
    repeat (3) step();
    add_pkt(1, 4, 8'h61, 1'b1);
    drive();
    for (int k = 0; k < 10 && got_q.size() < 2; k++) step();
    #1;
    checks++; if (bus.wr_uart !== 1'b1) begin errors++; $display("FAIL t5_pre_wr got=%0b exp=1", bus.wr_uart); end
    checks++; if (dbg.rr_ptr !== 3'd3) begin errors++; $display("FAIL t5_pre_ptr got=%0d exp=3", dbg.rr_ptr); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.wr_uart !== 1'b0) begin errors++; $display("FAIL t5_wr got=%0b exp=0", bus.wr_uart); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t5_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL t5_ready got=%b exp=0000", bus.req_ready); end
    do_reset();
    add_pkt(1, 1, 8'h70, 1'b1);
    add_pkt(3, 1, 8'h73, 1'b1);
    drive();
    step();
    step();
    checks++; if (s_grant !== 2'd1) begin errors++; $display("FAIL t5_restart_grant got=%0d exp=1", s_grant); end
    checks++; if (s_wdata !== 8'h70) begin errors++; $display("FAIL t5_restart_byte got=%0h exp=70", s_wdata); end
  endtask

  task automatic test_wrap_single();
    int n0;
    do_reset();
    add_pkt(2, 1, 8'h80, 1'b1);
    drive();
    step();
    step();
    add_pkt(0, 1, 8'h81, 1'b1);
    add_pkt(2, 1, 8'h82, 1'b1);
    drive();
    step();
    checks++; if (s_ptr !== 3'd3) begin errors++; $display("FAIL t6_ptr got=%0d exp=3", s_ptr); end
    step();
    checks++; if (s_grant !== 2'd0) begin errors++; $display("FAIL t6_grant got=%0d exp=0", s_grant); end
    checks++; if (s_wr !== 1'b1 || s_wdata !== 8'h81) begin errors++; $display("FAIL t6_byte got=%0h/%0b exp=81/1", s_wdata, s_wr); end
    step();
    checks++; if (s_busy !== 1'b0 || s_wr !== 1'b0) begin errors++; $display("FAIL t6_idle got=%0b/%0b exp=0/0", s_busy, s_wr); end
    checks++; if (s_ptr !== 3'd1) begin errors++; $display("FAIL t6_ptr_after got=%0d exp=1", s_ptr); end
    step();
    checks++; if (s_grant !== 2'd2 || s_wdata !== 8'h82) begin errors++; $display("FAIL t6_second got=%0d/%0h exp=2/82", s_grant, s_wdata); end
    n0 = 0;
    foreach (got_id_q[k]) if (got_id_q[k] == 0) n0++;
    checks++; if (n0 !== 1) begin errors++; $display("FAIL t6_one_pulse got=%0d exp=1", n0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n       = 1'b0;
    bus.tx_full   = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    hold          = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_packet();
    test_wrap_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
